spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receiving end of the neuron spike interface: it turns a 1-bit spike train back into a multi-bit rate value. It counts spike rising edges over a programmable window of clock cycles and reports the count as a registered rate with a one-cycle valid strobe. It sits downstream of a LIF neuron's spike output, for display or for feeding a next-layer current input.

Parameters:
- CNT_W, 8, width of the spike accumulator and the rate output
- WIN_W, 8, width of window_len and the internal window counter
- TRACE_W, 8, width of the trace output (optional feature only)
- TRACE_WEIGHT, 32, increment added to the trace per spike edge (optional feature only)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- spike  input  1  spike level from neuron; may stay high for several cycles
- enable  input  1  run counting windows while high
- window_len  input  WIN_W  window length in cycles; 0 = no windows run
- rate  output  CNT_W  spike-edge count of the last completed window
- rate_valid  output  1  one-cycle strobe, rate updated this cycle
- saturated  output  1  last reported window overflowed the accumulator
- trace  output  TRACE_W  leaky spike trace (driven 0 when feature is off)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, spike_q=0, acc=0, win_cnt=0, rate=0, rate_valid=0, saturated=0, trace=0. Reset mid-window discards the partial count; no report is made.
- Edge detect: edge = spike & ~spike_q. spike_q <= spike every cycle, independent of enable, so a level held across an enable change is not recounted.
- FSM, IDLE:
  - rate_valid=0, acc=0.
  - If enable=1 and window_len!=0: go to COUNT and load win_cnt=window_len-1.
  - The first counted cycle is the cycle after entry.
- FSM, COUNT, each cycle:
  - If enable=0: go to IDLE, acc<=0, no report; rate and saturated hold.
  - Else, if win_cnt!=0: acc <= sat(acc+edge), win_cnt <= win_cnt-1.
  - Else (last window cycle):
    - rate <= sat(acc+edge), rate_valid <= 1 for one cycle, saturated <= 1 if acc+edge exceeded 2^CNT_W-1.
    - acc <= 0.
    - win_cnt <= window_len-1, with window_len resampled here. If window_len is now 0, go to IDLE.
    - Windows are back-to-back with no gap cycles.
- sat(): clamp at 2^CNT_W-1. Once clamped, acc stays at max for the rest of the window.
- Latency: a window spans exactly window_len cycles. rate/rate_valid appear on the clock edge ending the last window cycle, so the edge in that final cycle is counted.
- Changes to window_len mid-window take effect only at the next window boundary.
- rate_valid is never high for two consecutive cycles unless window_len=1. With window_len=1, rate_valid is high every cycle.

Optional Feature:
- Macro: SPIKE_RATE_DECODER_TRACE_EN.
- Defined:
  - trace <= sat(trace - (trace>>3) + (edge ? TRACE_WEIGHT : 0)) every cycle, leak factor 0.875.
  - Runs regardless of enable; reset to 0.
  - Saturates at 2^TRACE_W-1.
- Undefined: trace tied to 0, no trace register.

Test Plan:
- Reset then enable=1, window_len=10, spike one-cycle pulses every 2nd cycle -> rate_valid every 10 cycles, rate=5, saturated=0.
- spike held high 20 cycles, window_len=32 -> rate=1 (single edge counted).
- CNT_W=4, window_len=40, alternating spike -> rate=15, saturated=1. Next window with no spikes -> rate=0, saturated=0.
- Assert rst=1 mid-window after 3 edges with window_len=10 -> all outputs 0. First report after reset counts only post-reset edges.
- Drop enable mid-window -> no rate_valid, rate holds previous value. Re-enable -> fresh window of window_len cycles. window_len=0 -> never rate_valid.
- With SPIKE_RATE_DECODER_TRACE_EN, single spike edge -> trace 32, 28, 25, 22 on successive cycles. Without the macro -> trace stays 0.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts spike rising edges over a programmable window.
// Optional leaky trace output enabled by defining SPIKE_RATE_DECODER_TRACE_EN.
module spike_rate_decoder #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned WIN_W        = 8,
    parameter int unsigned TRACE_W      = 8,
    parameter int unsigned TRACE_WEIGHT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spike,
    input  logic               enable,
    input  logic [WIN_W-1:0]   window_len,
    output logic [CNT_W-1:0]   rate,
    output logic               rate_valid,
    output logic               saturated,
    output logic [TRACE_W-1:0] trace
);

    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t             state, state_next;
    logic               spike_q;
    logic               spike_edge;
    logic [CNT_W-1:0]   acc, acc_next;
    logic               ovf, ovf_next;
    logic [WIN_W-1:0]   win_cnt, win_next;
    logic [CNT_W-1:0]   rate_next;
    logic               rate_valid_next;
    logic               saturated_next;
    logic [SUM_W-1:0]   sum;
    logic               sum_ovf;
    logic [CNT_W-1:0]   sum_sat;

    assign spike_edge = spike & ~spike_q;
    assign sum        = {1'b0, acc} + SUM_W'(spike_edge);
    assign sum_ovf    = sum[CNT_W];
    assign sum_sat    = sum_ovf ? CNT_MAX : sum[CNT_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && window_len != '0) state_next = COUNT;
            COUNT: begin
                if (!enable)                                  state_next = IDLE;
                else if (win_cnt == '0 && window_len == '0)   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values; ovf keeps the window's overflow once acc has clamped
    always_comb begin
        acc_next        = acc;
        ovf_next        = ovf;
        win_next        = win_cnt;
        rate_next       = rate;
        rate_valid_next = 1'b0;
        saturated_next  = saturated;
        case (state)
            IDLE: begin
                acc_next = '0;
                ovf_next = 1'b0;
                if (enable && window_len != '0) win_next = window_len - WIN_W'(1);
            end
            COUNT: begin
                if (!enable) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                end else if (win_cnt != '0) begin
                    acc_next = sum_sat;
                    ovf_next = ovf | sum_ovf;
                    win_next = win_cnt - WIN_W'(1);
                end else begin
                    rate_next       = sum_sat;
                    rate_valid_next = 1'b1;
                    saturated_next  = ovf | sum_ovf;
                    acc_next        = '0;
                    ovf_next        = 1'b0;
                    win_next        = (window_len == '0) ? '0 : window_len - WIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q    <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
            win_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            spike_q    <= spike;
            acc        <= acc_next;
            ovf        <= ovf_next;
            win_cnt    <= win_next;
            rate       <= rate_next;
            rate_valid <= rate_valid_next;
            saturated  <= saturated_next;
        end
    end

`ifdef SPIKE_RATE_DECODER_TRACE_EN
    localparam int unsigned TSUM_W = TRACE_W + 33;
    localparam logic [TRACE_W-1:0] TRACE_MAX = '1;

    logic [TRACE_W-1:0] trace_decay;
    logic [TSUM_W-1:0]  trace_sum;

    // Leak by 1/8 per cycle, add weight on each spike edge, clamp at max
    assign trace_decay = trace - (trace >> 3);
    assign trace_sum   = TSUM_W'(trace_decay) + (spike_edge ? TSUM_W'(TRACE_WEIGHT) : '0);

    always_ff @(posedge clk) begin
        if (rst)                                 trace <= '0;
        else if (trace_sum > TSUM_W'(TRACE_MAX)) trace <= TRACE_MAX;
        else                                     trace <= trace_sum[TRACE_W-1:0];
    end
`else
    assign trace = TRACE_W'(TRACE_WEIGHT * 0);
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table-driven windows plus corner sequences.
module tb_spike_rate_decoder;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WIN_W   = 8;
    localparam int unsigned TRACE_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               spike;
    logic               enable;
    logic [WIN_W-1:0]   window_len;
    logic [CNT_W-1:0]   rate;
    logic               rate_valid;
    logic               saturated;
    logic [TRACE_W-1:0] trace;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .TRACE_W(TRACE_W), .TRACE_WEIGHT(32)
    ) dut (
        .clk(clk), .rst(rst), .spike(spike), .enable(enable), .window_len(window_len),
        .rate(rate), .rate_valid(rate_valid), .saturated(saturated), .trace(trace)
    );

    typedef struct {
        logic [CNT_W-1:0] rate;
        logic             sat;
    } exp_t;

    typedef struct {
        int wlen;
        int period;
        int width;
        int nwin;
        int exp_rate;
        int exp_sat;
    } row_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: every reported window must match the oldest pending expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rate_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_rate", int'(rate), int'(e.rate));
                check("sb_sat", int'(saturated), int'(e.sat));
            end
        end
    end

    task automatic push(input int r, input int s);
        exp_t e;
        e.rate = CNT_W'(r);
        e.sat  = s[0];
        sb_q.push_back(e);
    endtask

    task automatic step(input logic s);
        spike = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        enable = 1'b0;
        repeat (3) step(1'b0);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    row_t rows [5];
    int   trace_exp [4];
    logic pat [5];
    logic prev;

    initial begin
        rows[0] = '{10, 2, 1, 3, 5, 0};
        rows[1] = '{32, 64, 20, 1, 1, 0};
        rows[2] = '{40, 2, 1, 1, 15, 1};
        rows[3] = '{4, 4, 2, 4, 1, 0};
        rows[4] = '{16, 8, 0, 2, 0, 0};
`ifdef SPIKE_RATE_DECODER_TRACE_EN
        trace_exp = '{32, 28, 25, 22};
`else
        trace_exp = '{0, 0, 0, 0};
`endif
        spike      = 1'b0;
        enable     = 1'b0;
        window_len = '0;

        do_reset();
        check("reset_rate", int'(rate), 0);
        check("reset_valid", int'(rate_valid), 0);
        check("reset_sat", int'(saturated), 0);
        check("reset_trace", int'(trace), 0);

        // Table-driven periodic spike trains, identical count per window
        for (int r = 0; r < 5; r++) begin
            do_reset();
            window_len = WIN_W'(rows[r].wlen);
            enable     = 1'b1;
            step(1'b0);
            for (int w = 0; w < rows[r].nwin; w++) begin
                push(rows[r].exp_rate, rows[r].exp_sat);
                for (int c = 0; c < rows[r].wlen; c++) begin
                    int i;
                    i = w * rows[r].wlen + c;
                    step(((i % rows[r].period) < rows[r].width) ? 1'b1 : 1'b0);
                    check("row_valid_timing", int'(rate_valid), (c == rows[r].wlen - 1) ? 1 : 0);
                end
            end
            drain("row_drain");
        end

        // Saturated window followed by an empty window clears saturated
        do_reset();
        window_len = WIN_W'(40);
        enable     = 1'b1;
        step(1'b0);
        push(15, 1);
        for (int c = 0; c < 40; c++) step((c % 2 == 0) ? 1'b1 : 1'b0);
        check("sat_valid", int'(rate_valid), 1);
        push(0, 0);
        for (int c = 0; c < 40; c++) step(1'b0);
        check("unsat_valid", int'(rate_valid), 1);
        check("unsat_rate", int'(rate), 0);
        check("unsat_flag", int'(saturated), 0);
        drain("sat_drain");

        // Reset mid-window discards the partial count
        do_reset();
        window_len = WIN_W'(10);
        enable     = 1'b1;
        step(1'b0);
        push(5, 0);
        for (int c = 0; c < 10; c++) step((c % 2 == 0) ? 1'b1 : 1'b0);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        rst = 1'b1;
        step(1'b0);
        check("midrst_rate", int'(rate), 0);
        check("midrst_valid", int'(rate_valid), 0);
        check("midrst_sat", int'(saturated), 0);
        check("midrst_trace", int'(trace), 0);
        rst = 1'b0;
        step(1'b0);
        push(2, 0);
        for (int c = 0; c < 10; c++) begin
            step((c == 0 || c == 9) ? 1'b1 : 1'b0);
            check("postrst_valid", int'(rate_valid), (c == 9) ? 1 : 0);
        end
        drain("rst_drain");

        // Enable drop mid-window: no report, rate holds, re-enable starts fresh
        do_reset();
        window_len = WIN_W'(10);
        enable     = 1'b1;
        step(1'b0);
        push(5, 0);
        for (int c = 0; c < 10; c++) step((c % 2 == 0) ? 1'b1 : 1'b0);
        for (int c = 0; c < 4; c++) step((c % 2 == 0) ? 1'b1 : 1'b0);
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            check("drop_valid", int'(rate_valid), 0);
            check("drop_hold_rate", int'(rate), 5);
        end
        enable = 1'b1;
        step(1'b0);
        push(2, 0);
        for (int c = 0; c < 10; c++) begin
            step((c == 0 || c == 9) ? 1'b1 : 1'b0);
            check("reen_valid", int'(rate_valid), (c == 9) ? 1 : 0);
        end
        drain("drop_drain");

        // window_len = 0 never reports
        do_reset();
        window_len = '0;
        enable     = 1'b1;
        for (int c = 0; c < 30; c++) step((c % 2 == 0) ? 1'b1 : 1'b0);
        check("zero_len_valid", int'(rate_valid), 0);
        drain("zero_drain");

        // window_len = 1 reports every cycle
        do_reset();
        window_len = WIN_W'(1);
        enable     = 1'b1;
        step(1'b0);
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        prev = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push((pat[c] && !prev) ? 1 : 0, 0);
            prev = pat[c];
            step(pat[c]);
            check("len1_valid", int'(rate_valid), 1);
        end
        drain("len1_drain");

        // Trace response to a single edge held for two cycles
        do_reset();
        step(1'b0);
        step(1'b1);
        check("trace_0", int'(trace), trace_exp[0]);
        step(1'b1);
        check("trace_1", int'(trace), trace_exp[1]);
        step(1'b0);
        check("trace_2", int'(trace), trace_exp[2]);
        step(1'b0);
        check("trace_3", int'(trace), trace_exp[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
